dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data-memory (dmem) port between the processor and a host/loader requester, such as a debug or program-loading engine. It sits between the processor's dmem signals and the dmem syncram instance in the top-level wrapper. It grants at most one access per cycle and returns read data to the requester that issued the read. A starvation counter guarantees forward progress for the host under fixed priority.

---
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares one dmem port between processor and host; zero-latency grant, one-cycle read return.
// Optional round-robin arbitration when DMEM_ARB_RR_EN is defined (default: fixed priority + starvation override).
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 15
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_p_req,
  input  logic              i_p_wren,
  input  logic [ADDR_W-1:0] i_p_addr,
  input  logic [DATA_W-1:0] i_p_wdata,
  input  logic              i_h_req,
  input  logic              i_h_wren,
  input  logic [ADDR_W-1:0] i_h_addr,
  input  logic [DATA_W-1:0] i_h_wdata,
  output logic              o_p_gnt,
  output logic              o_h_gnt,
  output logic              o_p_rvalid,
  output logic              o_h_rvalid,
  output logic [DATA_W-1:0] o_p_rdata,
  output logic [DATA_W-1:0] o_h_rdata,
  output logic [ADDR_W-1:0] o_address_dmem,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wren,
  input  logic [DATA_W-1:0] i_q_dmem,
  output logic              o_busy
);

  // state   | meaning
  // ST_NONE | nothing granted since reset
  // ST_PROC | most recent grant went to the processor
  // ST_HOST | most recent grant went to the host
  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_PROC = 2'd1,
    ST_HOST = 2'd2
  } owner_t;

  owner_t r_last;
  owner_t w_last_nxt;
  logic   w_p_gnt;
  logic   w_h_gnt;
  logic   w_h_pri;
  logic   r_rd_pend;
  logic   r_rd_owner;

`ifndef DMEM_ARB_RR_EN
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  logic [7:0] r_starve;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_starve <= 8'd0;
    end else if (i_h_req && !w_h_gnt) begin
      if (r_starve != 8'hFF) r_starve <= r_starve + 8'd1;
    end else begin
      r_starve <= 8'd0;
    end
  end
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) r_last <= ST_NONE;
    else         r_last <= w_last_nxt;
  end

  always_comb begin
    w_last_nxt = r_last;
    if (w_p_gnt)      w_last_nxt = ST_PROC;
    else if (w_h_gnt) w_last_nxt = ST_HOST;
  end

  // Host wins a contested cycle only when w_h_pri; reset blocks every grant.
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    w_h_pri = (r_last == ST_PROC);
`else
    w_h_pri = (r_starve >= STARVE_LIM);
`endif
    w_h_gnt = !i_reset && i_h_req && (!i_p_req || w_h_pri);
    w_p_gnt = !i_reset && i_p_req && !w_h_gnt;
  end

  always_comb begin
    o_address_dmem = '0;
    o_data         = '0;
    o_wren         = 1'b0;
    if (w_p_gnt) begin
      o_address_dmem = i_p_addr;
      o_data         = i_p_wdata;
      o_wren         = i_p_wren;
    end else if (w_h_gnt) begin
      o_address_dmem = i_h_addr;
      o_data         = i_h_wdata;
      o_wren         = i_h_wren;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_rd_pend  <= (w_p_gnt || w_h_gnt) && !o_wren;
      r_rd_owner <= w_h_gnt;
    end
  end

  // Gating by reset suppresses a return whose read was granted just before reset.
  always_comb begin
    o_p_gnt    = w_p_gnt;
    o_h_gnt    = w_h_gnt;
    o_p_rvalid = !i_reset && r_rd_pend && !r_rd_owner;
    o_h_rvalid = !i_reset && r_rd_pend && r_rd_owner;
    o_p_rdata  = o_p_rvalid ? i_q_dmem : '0;
    o_h_rdata  = o_h_rvalid ? i_q_dmem : '0;
    o_busy     = !i_reset && (w_p_gnt || w_h_gnt || r_rd_pend);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read memory model; STARVE_MAX set to 3.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_req, p_wren, h_req, h_wren;
  logic [11:0] p_addr, h_addr;
  logic [31:0] p_wdata, h_wdata;
  logic        p_gnt, h_gnt, p_rvalid, h_rvalid, wren, busy;
  logic [31:0] p_rdata, h_rdata, data, q_dmem;
  logic [11:0] address_dmem;
  logic [31:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(3)) dut (
    .i_clock(clk), .i_reset(reset),
    .i_p_req(p_req), .i_p_wren(p_wren), .i_p_addr(p_addr), .i_p_wdata(p_wdata),
    .i_h_req(h_req), .i_h_wren(h_wren), .i_h_addr(h_addr), .i_h_wdata(h_wdata),
    .o_p_gnt(p_gnt), .o_h_gnt(h_gnt), .o_p_rvalid(p_rvalid), .o_h_rvalid(h_rvalid),
    .o_p_rdata(p_rdata), .o_h_rdata(h_rdata), .o_address_dmem(address_dmem),
    .o_data(data), .o_wren(wren), .i_q_dmem(q_dmem), .o_busy(busy)
  );

  always @(posedge clk) begin
    if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  typedef struct {
    logic        p_req, p_wren;
    logic [11:0] p_addr;
    logic [31:0] p_wdata;
    logic        h_req, h_wren;
    logic [11:0] h_addr;
    logic [31:0] h_wdata;
    logic        e_pg, e_hg;
    logic [11:0] e_addr;
    logic [31:0] e_data;
    logic        e_wren, e_prv, e_hrv;
    logic [31:0] e_prd, e_hrd;
    logic        e_busy;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pr, input logic pw, input logic [11:0] pa, input logic [31:0] pd,
                       input logic hr, input logic hw, input logic [11:0] ha, input logic [31:0] hd);
    p_req = pr; p_wren = pw; p_addr = pa; p_wdata = pd;
    h_req = hr; h_wren = hw; h_addr = ha; h_wdata = hd;
  endtask

  task automatic idle();
    drive(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
  endtask

  initial begin
    logic exp_h, prev_p, prev_h;
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    mem[12'h010] = 32'hDEADBEEF;

    vecs[0] = '{0,0,12'h000,32'h0,        0,0,12'h000,32'h0,        0,0,12'h000,32'h0,        0,0,0,32'h0,        32'h0,        0};
    vecs[1] = '{1,1,12'h030,32'hA5A50001, 0,0,12'h000,32'h0,        1,0,12'h030,32'hA5A50001, 1,0,0,32'h0,        32'h0,        1};
    vecs[2] = '{0,0,12'h000,32'h0,        1,1,12'h040,32'h0000BEEF, 0,1,12'h040,32'h0000BEEF, 1,0,0,32'h0,        32'h0,        1};
    vecs[3] = '{1,0,12'h030,32'h00001111, 0,0,12'h000,32'h0,        1,0,12'h030,32'h00001111, 0,0,0,32'h0,        32'h0,        1};
    vecs[4] = '{0,0,12'h000,32'h0,        1,0,12'h040,32'h00002222, 0,1,12'h040,32'h00002222, 0,1,0,32'hA5A50001, 32'h0,        1};
    vecs[5] = '{1,0,12'h7FF,32'h00003333, 1,1,12'h001,32'h00004444, 1,0,12'h7FF,32'h00003333, 0,0,1,32'h0,        32'h0000BEEF, 1};
    vecs[6] = '{0,0,12'h000,32'h0,        1,1,12'h002,32'h00005555, 0,1,12'h002,32'h00005555, 1,1,0,32'h000007FF, 32'h0,        1};
    vecs[7] = '{1,1,12'hFFF,32'h00006666, 1,0,12'h003,32'h00007777, 1,0,12'hFFF,32'h00006666, 1,0,0,32'h0,        32'h0,        1};
    vecs[8] = '{0,0,12'h000,32'h0,        0,0,12'h000,32'h0,        0,0,12'h000,32'h0,        0,0,0,32'h0,        32'h0,        0};

    // Reset held two cycles with both requesting.
    reset = 1'b1;
    drive(1, 1, 12'h0FF, 32'h0, 1, 1, 12'h0FE, 32'h99);
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_p_gnt", p_gnt, 0);
      chk("rst_h_gnt", h_gnt, 0);
      chk("rst_wren", wren, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addr", address_dmem, 0);
      chk("rst_data", data, 0);
      chk("rst_rvalid", {p_rvalid, h_rvalid}, 0);
      chk("rst_rdata", {p_rdata, h_rdata}, 0);
    end
    @(negedge clk); reset = 1'b0; #1;
    chk("rel_p_gnt", p_gnt, 1);
    chk("rel_h_gnt", h_gnt, 0);
    @(negedge clk); idle();

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].p_req, vecs[i].p_wren, vecs[i].p_addr, vecs[i].p_wdata,
            vecs[i].h_req, vecs[i].h_wren, vecs[i].h_addr, vecs[i].h_wdata);
      #1;
      chk($sformatf("v%0d_p_gnt", i), p_gnt, vecs[i].e_pg);
      chk($sformatf("v%0d_h_gnt", i), h_gnt, vecs[i].e_hg);
      chk($sformatf("v%0d_addr", i), address_dmem, vecs[i].e_addr);
      chk($sformatf("v%0d_data", i), data, vecs[i].e_data);
      chk($sformatf("v%0d_wren", i), wren, vecs[i].e_wren);
      chk($sformatf("v%0d_p_rvalid", i), p_rvalid, vecs[i].e_prv);
      chk($sformatf("v%0d_h_rvalid", i), h_rvalid, vecs[i].e_hrv);
      chk($sformatf("v%0d_p_rdata", i), p_rdata, vecs[i].e_prd);
      chk($sformatf("v%0d_h_rdata", i), h_rdata, vecs[i].e_hrd);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
    end

    // Processor read of preloaded word.
    @(negedge clk); drive(1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0); #1;
    chk("pread_gnt", p_gnt, 1);
    chk("pread_addr", address_dmem, 12'h010);
    @(negedge clk); idle(); #1;
    chk("pread_rvalid", p_rvalid, 1);
    chk("pread_rdata", p_rdata, 32'hDEADBEEF);
    chk("pread_h_rvalid", h_rvalid, 0);
    chk("pread_busy", busy, 1);

    // Host write then processor read of the same address.
    @(negedge clk); drive(0, 0, 12'h0, 32'h0, 1, 1, 12'h020, 32'h00001234); #1;
    chk("hwr_gnt", h_gnt, 1);
    chk("hwr_wren", wren, 1);
    chk("hwr_p_rvalid", p_rvalid, 0);
    @(negedge clk); drive(1, 0, 12'h020, 32'h0, 0, 0, 12'h0, 32'h0); #1;
    chk("rdaw_gnt", p_gnt, 1);
    @(negedge clk); idle(); #1;
    chk("rdaw_rvalid", p_rvalid, 1);
    chk("rdaw_rdata", p_rdata, 32'h00001234);

    // Reset one cycle after a granted read.
    @(negedge clk); drive(1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0); #1;
    chk("rmid_gnt", p_gnt, 1);
    @(negedge clk); reset = 1'b1; idle(); #1;
    chk("rmid_rvalid_n1", p_rvalid, 0);
    chk("rmid_busy_n1", busy, 0);
    @(negedge clk); reset = 1'b0; #1;
    chk("rmid_rvalid_n2", p_rvalid, 0);
    chk("rmid_rdata_n2", p_rdata, 0);
`ifndef DMEM_ARB_RR_EN
    chk("rmid_starve", dut.r_starve, 0);
`endif

    // Continuous contention: p reads 0x010, h reads 0x040.
    prev_p = 1'b0;
    prev_h = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); drive(1, 0, 12'h010, 32'h0, 1, 0, 12'h040, 32'h0); #1;
`ifdef DMEM_ARB_RR_EN
      exp_h = (k % 2 == 1);
`else
      exp_h = (k % 4 == 3);
`endif
      chk($sformatf("cont%0d_p_gnt", k), p_gnt, !exp_h);
      chk($sformatf("cont%0d_h_gnt", k), h_gnt, exp_h);
      chk($sformatf("cont%0d_addr", k), address_dmem, exp_h ? 12'h040 : 12'h010);
      chk($sformatf("cont%0d_p_rvalid", k), p_rvalid, prev_p);
      chk($sformatf("cont%0d_h_rvalid", k), h_rvalid, prev_h);
      chk($sformatf("cont%0d_p_rdata", k), p_rdata, prev_p ? 32'hDEADBEEF : 32'h0);
      chk($sformatf("cont%0d_h_rdata", k), h_rdata, prev_h ? 32'h0000BEEF : 32'h0);
      prev_p = !exp_h;
      prev_h = exp_h;
    end
    @(negedge clk); idle(); #1;
    chk("cont_end_p_rvalid", p_rvalid, prev_p);
    chk("cont_end_h_rvalid", h_rvalid, prev_h);
    chk("cont_end_gnt", {p_gnt, h_gnt}, 0);

    @(negedge clk); #1;
    chk("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
